// File: rtl/dma_read_multi.sv
// dma_read_multi: walks a latched table of up to NSEG read segments.
// For each non-empty segment it issues one DMA ctrl request, then streams
// the returned beats into the selected SRAM bank (0 = weight, 1 = activation),
// masking off lanes past the segment length on the final beat.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. The ctrl request holds valid and its index/length fields
// steady until accepted. Beat ready is decoded from the DATA state only, so it
// drops in the cycle after the last beat has been taken.
module dma_read_multi #(
    parameter int          NSEG       = 4,
    parameter int          DMA_WIDTH  = 64,
    parameter int          WORD_WIDTH = 32,
    parameter int          ADDR_WIDTH = 16,
    parameter logic [2:0]  SIZE_CODE  = 3'b010,
    localparam int         LANES      = DMA_WIDTH / WORD_WIDTH,
    localparam int         CNT_W      = $clog2(NSEG + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           seg_count,
    input  logic [NSEG*32-1:0]         seg_index,
    input  logic [NSEG*32-1:0]         seg_length,
    input  logic [NSEG-1:0]            seg_dst,
    input  logic [NSEG*ADDR_WIDTH-1:0] seg_base,
    output logic                       dma_read_ctrl_valid,
    input  logic                       dma_read_ctrl_ready,
    output logic [31:0]                dma_read_ctrl_data_index,
    output logic [31:0]                dma_read_ctrl_data_length,
    output logic [2:0]                 dma_read_ctrl_data_size,
    input  logic                       dma_read_chnl_valid,
    output logic                       dma_read_chnl_ready,
    input  logic [DMA_WIDTH-1:0]       dma_read_chnl_data,
    output logic                       wr_en,
    output logic                       wr_sel,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [DMA_WIDTH-1:0]       wr_data,
    output logic [LANES-1:0]           wr_mask,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_CTRL  = 3'd2,
        S_DATA  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                    state_q, state_d;

    // Descriptor table captured on the accepted start cycle.
    logic [CNT_W-1:0]          seg_cnt_q;
    logic [NSEG*32-1:0]        idx_tab_q;
    logic [NSEG*32-1:0]        len_tab_q;
    logic [NSEG-1:0]           dst_tab_q;
    logic [NSEG*ADDR_WIDTH-1:0] base_tab_q;

    // Segment pointer and word offset of the next beat within the segment.
    logic [CNT_W-1:0]          seg_q, seg_d;
    logic [31:0]               word_q, word_d;
    logic [CNT_W-1:0]          seg_nxt;

    // Registered SRAM write port.
    logic                      wr_en_q, wr_en_d;
    logic                      wr_sel_q, wr_sel_d;
    logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [DMA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic [LANES-1:0]          wr_mask_q, wr_mask_d;

    // Fields of the currently selected segment.
    logic [31:0]               sel_idx;
    logic [31:0]               sel_len;
    logic                      sel_dst;
    logic [ADDR_WIDTH-1:0]     sel_base;

    logic                      start_acc;
    logic                      beat_acc;
    logic                      last_word;
    logic [LANES-1:0]          lane_mask;
    logic [ADDR_WIDTH-1:0]     beat_addr;

    // Select the descriptor fields of segment seg_q from the latched table.
    always_comb begin
        sel_idx  = '0;
        sel_len  = '0;
        sel_dst  = 1'b0;
        sel_base = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (seg_q == CNT_W'(k)) begin
                sel_idx  = idx_tab_q[k*32 +: 32];
                sel_len  = len_tab_q[k*32 +: 32];
                sel_dst  = dst_tab_q[k];
                sel_base = base_tab_q[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Beat bookkeeping: acceptance, last-beat detect, lane mask and address.
    always_comb begin
        start_acc = (state_q == S_IDLE) && start;
        beat_acc  = (state_q == S_DATA) && dma_read_chnl_valid;
        last_word = ({1'b0, word_q} + 33'(LANES)) >= {1'b0, sel_len};
        lane_mask = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_mask[j] = ({1'b0, word_q} + 33'(j)) < {1'b0, sel_len};
        end
        beat_addr = sel_base + word_q[ADDR_WIDTH-1:0];
        seg_nxt   = seg_q + CNT_W'(1);
    end

    // Next-state logic of the segment walker.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (seg_count == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: state_d = (sel_len == 32'd0) ? S_NEXT : S_CTRL;
            S_CTRL: begin
                if (dma_read_ctrl_ready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_acc && last_word) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT:  state_d = (seg_nxt == seg_cnt_q) ? S_DONE : S_SETUP;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the segment pointer, word offset and write port.
    always_comb begin
        seg_d     = seg_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_mask_d = '0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_acc) begin
            seg_d = '0;
        end
        if (state_q == S_SETUP) begin
            word_d = '0;
        end
        if (state_q == S_NEXT) begin
            seg_d = seg_nxt;
        end
        if (beat_acc) begin
            word_d    = word_q + 32'(LANES);
            wr_en_d   = 1'b1;
            wr_mask_d = lane_mask;
            wr_sel_d  = sel_dst;
            wr_addr_d = beat_addr;
            wr_data_d = dma_read_chnl_data;
        end
    end

    // State, counters and write port registers; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            seg_cnt_q <= '0;
            seg_q     <= '0;
            word_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            word_q    <= word_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
            if (start_acc) begin
                seg_cnt_q <= seg_count;
            end
        end
    end

    // Descriptor capture; only the start cycle in IDLE loads the table.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            idx_tab_q  <= seg_index;
            len_tab_q  <= seg_length;
            dst_tab_q  <= seg_dst;
            base_tab_q <= seg_base;
        end
    end

    // Outputs decoded from the state register and the write registers.
    always_comb begin
        dma_read_ctrl_valid       = (state_q == S_CTRL);
        dma_read_ctrl_data_index  = (state_q == S_CTRL) ? sel_idx : 32'd0;
        dma_read_ctrl_data_length = (state_q == S_CTRL) ? sel_len : 32'd0;
        dma_read_ctrl_data_size   = SIZE_CODE;
        dma_read_chnl_ready       = (state_q == S_DATA);
        busy = (state_q == S_SETUP) || (state_q == S_CTRL) ||
               (state_q == S_DATA)  || (state_q == S_NEXT);
        done      = (state_q == S_DONE);
        wr_en     = wr_en_q;
        wr_sel    = wr_sel_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        wr_mask   = wr_mask_q;
        dbg_state = state_q;
    end

endmodule
